// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    // Byte lane select for a single-byte store at the given word offset.
    function automatic logic [3:0] be_from_off(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between fetch (I) and load/store (D),
// one transaction at a time, D-priority with a starvation guard for I.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STK_MAX = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    state_t        state_q;
    owner_t        owner_q;
    logic [SW-1:0] streak_q;
    logic [TW-1:0] tmo_q;
    logic          discard_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic d_win, i_win, idle, resp, i_kill;

    // I is forced only once D has won STARVE_MAX times in a row over a waiting I.
    assign d_win  = d_req && !(streak_q == STK_MAX && i_req);
    assign i_win  = i_req && !d_win;
    assign idle   = (state_q == IDLE) && !rst;
    assign resp   = (state_q == RESP) && !rst;
    assign i_gnt  = idle && i_win;
    assign d_gnt  = idle && d_win;

    // A flush seen in the RESP cycle itself must still hide the fetch response.
    assign i_kill   = (owner_q == OWN_I) && (discard_q || i_flush);
    assign i_rvalid = resp && (owner_q == OWN_I) && !i_kill;
    assign d_rvalid = resp && (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? rdata_q : 32'h0;
    assign d_rdata  = d_rvalid ? rdata_q : 32'h0;
    assign err      = resp && err_q && !i_kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            streak_q  <= '0;
            tmo_q     <= '0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q   <= WAIT;
                        m_req     <= 1'b1;
                        tmo_q     <= '0;
                        err_q     <= 1'b0;
                        rdata_q   <= '0;
                        discard_q <= i_win && i_flush;
                        if (d_win) begin
                            owner_q  <= OWN_D;
                            m_we     <= d_we;
                            m_addr   <= d_addr;
                            m_be     <= d_we ? be_from_off(d_addr[1:0]) : 4'hF;
                            m_wdata  <= d_we ? {4{d_wdata}} : 32'h0;
                            streak_q <= !i_req ? '0 :
                                        (streak_q == STK_MAX) ? streak_q : streak_q + 1'b1;
                        end else begin
                            owner_q  <= OWN_I;
                            m_we     <= 1'b0;
                            m_addr   <= i_addr;
                            m_be     <= 4'hF;
                            m_wdata  <= 32'h0;
                            streak_q <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (owner_q == OWN_I && i_flush) discard_q <= 1'b1;
                    if (m_ack) begin
                        rdata_q <= m_we ? 32'h0 : m_rdata;
                        m_req   <= 1'b0;
                        state_q <= RESP;
                    end else if (tmo_q == TMO_MAX) begin
                        m_req   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    if (owner_q == OWN_I && i_flush) discard_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
